pc_sequencer: RTL and testbench

//  Fetch/redirect controller for the core front end. Owns the PC register, issues

---
 rtl/pc_sequencer.sv | 143 ++++++++++++++
 tb/tb_pc_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Front-end PC sequencer: owns the PC, fetches from imem and holds the word for execute.
// Optional retirement counter port instret is built when PC_PERF_CNT_EN is defined.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    input  logic        ex_done,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [31:0] sb_target,
    input  logic [31:0] uj_target,
    input  logic [31:0] jalr_target,
    output logic        trap,
    output logic [31:0] trap_addr
`ifdef PC_PERF_CNT_EN
    ,
    output logic [31:0] instret
`endif
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        EXEC,
        TRAP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_inc;
    logic [31:0] jalr_aligned;
    logic [31:0] next_pc;
    logic        misaligned;
    logic        ld_instr;
    logic        retire;
    logic        trap_q;
    logic [31:0] trap_addr_q;
    logic [31:0] instr_q;

    assign pc_inc       = pc + 32'd4;
    assign jalr_aligned = jalr_target & ~32'h1;

    // JALR outranks JAL, which outranks a taken branch.
    always_comb begin
        next_pc = pc_inc;
        if (is_jalr) begin
            next_pc = jalr_aligned;
        end else if (is_jal) begin
            next_pc = uj_target;
        end else if (branch_taken) begin
            next_pc = sb_target;
        end
    end

    assign misaligned = (next_pc[1:0] != 2'b00);

    always_comb begin
        state_nxt = state;
        ld_instr  = 1'b0;
        retire    = 1'b0;
        unique case (state)
            BOOT: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                if (imem_ready) begin
                    ld_instr  = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (ex_done && !stall) begin
                    retire    = 1'b1;
                    state_nxt = misaligned ? TRAP : FETCH;
                end
            end
            TRAP: begin
                state_nxt = TRAP;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_VECTOR;
            instr_q     <= 32'h0;
            trap_q      <= 1'b0;
            trap_addr_q <= 32'h0;
        end else begin
            state <= state_nxt;
            if (ld_instr) begin
                instr_q <= imem_rdata;
            end
            // A trapping retirement leaves pc on the faulting instruction.
            if (retire) begin
                if (misaligned) begin
                    trap_q      <= 1'b1;
                    trap_addr_q <= next_pc;
                end else begin
                    pc <= next_pc;
                end
            end
        end
    end

`ifdef PC_PERF_CNT_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= 32'h0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`endif

    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr       = instr_q;
    assign instr_valid = (state == EXEC);
    assign pc_out      = pc;
    assign trap        = trap_q;
    assign trap_addr   = trap_addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected fetch addresses are queued when
// execute resolves a redirect and popped when the DUT's fetch is accepted.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic        ex_done;
    logic        stall;
    logic        branch_taken;
    logic        is_jal;
    logic        is_jalr;
    logic [31:0] sb_target;
    logic [31:0] uj_target;
    logic [31:0] jalr_target;
    logic        trap;
    logic [31:0] trap_addr;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic        w_valid;
    logic [31:0] w_pc;
    logic        w_trap;
    logic [31:0] w_trap_addr;

`ifdef PC_PERF_CNT_EN
    logic [31:0] instret;
    logic [31:0] w_instret;
`endif

    int          n_chk;
    int          n_fail;
    int          retired;
    logic [31:0] exp_pc;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
    endfunction

    assign imem_rdata = mem(imem_addr);

    pc_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .ex_done     (ex_done),
        .stall       (stall),
        .branch_taken(branch_taken),
        .is_jal      (is_jal),
        .is_jalr     (is_jalr),
        .sb_target   (sb_target),
        .uj_target   (uj_target),
        .jalr_target (jalr_target),
        .trap        (trap),
        .trap_addr   (trap_addr)
`ifdef PC_PERF_CNT_EN
        ,
        .instret     (instret)
`endif
    );

    // Second copy starting at the top of the address space to exercise pc+4 wrap.
    pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_w (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (w_req),
        .imem_addr   (w_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (w_instr),
        .instr_valid (w_valid),
        .pc_out      (w_pc),
        .ex_done     (ex_done),
        .stall       (stall),
        .branch_taken(branch_taken),
        .is_jal      (is_jal),
        .is_jalr     (is_jalr),
        .sb_target   (sb_target),
        .uj_target   (uj_target),
        .jalr_target (jalr_target),
        .trap        (w_trap),
        .trap_addr   (w_trap_addr)
`ifdef PC_PERF_CNT_EN
        ,
        .instret     (w_instret)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_next(
        input logic [31:0] pc, input logic br, input logic jal,
        input logic jr, input logic [31:0] sb, input logic [31:0] uj,
        input logic [31:0] jt);
        if (jr) return {jt[31:1], 1'b0};
        if (jal) return uj;
        if (br) return sb;
        return pc + 32'd4;
    endfunction

    // Called just after a falling edge; observes the fetch about to be accepted.
    task automatic step();
        #4;
        if (imem_req && imem_ready) begin
            if (exp_q.size() == 0) begin
                chk("fetch_unexpected", 32'(imem_req), 32'd0);
            end else begin
                chk("fetch_addr", imem_addr, exp_q.pop_front());
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_redirect();
        ex_done      = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        is_jal       = 1'b0;
        is_jalr      = 1'b0;
        sb_target    = 32'h0;
        uj_target    = 32'h0;
        jalr_target  = 32'h0;
    endtask

    // One instruction: fetch at exp_pc, then retire with the given redirect.
    task automatic run_one(input logic br, input logic jal, input logic jr,
                           input logic [31:0] sb, input logic [31:0] uj,
                           input logic [31:0] jt);
        logic [31:0] nxt;
        step();
        chk("valid_exec", 32'(instr_valid), 32'd1);
        chk("req_exec", 32'(imem_req), 32'd0);
        chk("pc_out", pc_out, exp_pc);
        chk("instr", instr, mem(exp_pc));
        ex_done      = 1'b1;
        branch_taken = br;
        is_jal       = jal;
        is_jalr      = jr;
        sb_target    = sb;
        uj_target    = uj;
        jalr_target  = jt;
        nxt = model_next(exp_pc, br, jal, jr, sb, uj, jt);
        if (nxt[1:0] == 2'b00) exp_q.push_back(nxt);
        retired++;
        step();
        clear_redirect();
        if (nxt[1:0] != 2'b00) begin
            chk("trap", 32'(trap), 32'd1);
            chk("trap_addr", trap_addr, nxt);
            chk("req_trap", 32'(imem_req), 32'd0);
            chk("valid_trap", 32'(instr_valid), 32'd0);
            chk("pc_hold_trap", imem_addr, exp_pc);
        end else begin
            chk("valid_drop", 32'(instr_valid), 32'd0);
            chk("req_fetch", 32'(imem_req), 32'd1);
            exp_pc = nxt;
        end
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        retired    = 0;
        rst        = 1'b1;
        imem_ready = 1'b0;
        clear_redirect();
        @(negedge clk);
        @(negedge clk);

        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_trap_addr", trap_addr, 32'h0);
        chk("rst_w_addr", w_addr, 32'hFFFF_FFFC);

        // Straight-line fetch, ready always high.
        rst        = 1'b0;
        imem_ready = 1'b1;
        exp_pc     = 32'h0;
        exp_q.push_back(32'h0);
        step();
        chk("boot_to_fetch", 32'(imem_req), 32'd1);
        run_one(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("wrap_addr", w_addr, 32'h0);
        chk("wrap_req", 32'(w_req), 32'd1);
        run_one(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        run_one(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

        // Redirect priorities.
        run_one(1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 32'h0);
        run_one(1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 32'h0);
        run_one(1'b1, 1'b1, 1'b0, 32'h80, 32'h300, 32'h0);
        run_one(1'b1, 1'b1, 1'b1, 32'h80, 32'h400, 32'h205);
        chk("jalr_wins", exp_pc, 32'h204);

        // Stall holds the instruction; redirect inputs are ignored while stalled.
        step();
        ex_done      = 1'b1;
        stall        = 1'b1;
        branch_taken = 1'b1;
        sb_target    = 32'h40;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_pc", pc_out, exp_pc);
            chk("stall_instr", instr, mem(exp_pc));
        end
        stall        = 1'b0;
        branch_taken = 1'b0;
        exp_q.push_back(exp_pc + 32'd4);
        retired++;
        step();
        clear_redirect();
        exp_pc = exp_pc + 32'd4;
        chk("stall_retire_valid", 32'(instr_valid), 32'd0);
        chk("stall_retire_addr", imem_addr, exp_pc);

        // imem not ready: request and address held.
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", imem_addr, exp_pc);
        end

        // Async reset in the middle of a fetch.
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_req", 32'(imem_req), 32'd0);
        chk("midrst_addr", imem_addr, 32'h0);
        chk("midrst_instr", instr, 32'h0);
        @(negedge clk);
        rst        = 1'b0;
        imem_ready = 1'b1;
        retired    = 0;
        exp_q.delete();
        exp_pc = 32'h0;
        exp_q.push_back(32'h0);
        step();
        run_one(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

        // Misaligned JALR target traps and stays trapped.
        run_one(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h203);
        for (int i = 0; i < 3; i++) begin
            ex_done = 1'b1;
            step();
            chk("trap_sticky", 32'(trap), 32'd1);
            chk("trap_noreq", 32'(imem_req), 32'd0);
        end
        clear_redirect();
`ifdef PC_PERF_CNT_EN
        chk("instret", instret, 32'(retired));
`endif
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
